// File: rtl/tone_sequencer_if.sv
// Control, note-table programming and status bundle for the tone sequencer.
// The board controller drives the master side; the sequencer is the slave.
interface tone_sequencer_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned HALF_W = 16,
  parameter int unsigned LEN_W  = 8
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [HALF_W-1:0] cfg_half;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W:0]   num_notes;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] note_idx;
  logic              speaker;

  modport master (
    output cfg_we, cfg_addr, cfg_half, cfg_len, num_notes, start, stop,
    input  busy, done, note_idx, speaker
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_half, cfg_len, num_notes, start, stop,
    output busy, done, note_idx, speaker
  );
endinterface

// File: rtl/tone_sequencer.sv
// Sequenced square-wave tone source: steps through a writable table of
// {half-period, duration} entries and drives the speaker pin.
module tone_sequencer #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned HALF_W   = 16,
  parameter int unsigned LEN_W    = 8
) (
  input logic             clk,
  input logic             rst_n,
  tone_sequencer_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        idx_q;
  logic [ADDR_W-1:0]        last_q;
  logic [HALF_W-1:0]        half_q;
  logic [LEN_W-1:0]         len_q;
  logic [HALF_W-1:0]        tone_q;
  logic [PRE_W-1:0]         presc_q;
  logic [LEN_W-1:0]         dur_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     spk_q;

  logic [HALF_W+LEN_W-1:0]  mem_q [DEPTH];
  logic [HALF_W+LEN_W-1:0]  rd_entry;
  logic [HALF_W-1:0]        rd_half;
  logic [LEN_W-1:0]         rd_len;
  logic [HALF_W-1:0]        half_m1;
  logic [LEN_W-1:0]         dur_nxt;
  logic [ADDR_W-1:0]        last_d;
  logic                     note_end;
  logic                     skip;
  logic                     advance;
  logic                     is_last;

  // Table has no reset; nonblocking write keeps a same-cycle LOAD read-first.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      mem_q[bus.cfg_addr] <= {bus.cfg_half, bus.cfg_len};
    end
  end

  always_comb begin
    rd_entry = mem_q[idx_q];
    rd_half  = rd_entry[HALF_W+LEN_W-1:LEN_W];
    rd_len   = rd_entry[LEN_W-1:0];
    half_m1  = half_q - HALF_W'(1);
    dur_nxt  = dur_q + LEN_W'(1);
    // Top bit set means num_notes >= depth, so clamp to the last entry.
    last_d   = bus.num_notes[ADDR_W] ? '1 : bus.num_notes[ADDR_W-1:0] - ADDR_W'(1);
    note_end = (state_q == StPlay) && (presc_q == PreLast) && (dur_nxt == len_q);
    skip     = (state_q == StLoad) && (rd_len == '0);
    advance  = note_end || skip;
    is_last  = (idx_q == last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      half_q  <= '0;
      len_q   <= '0;
      tone_q  <= '0;
      presc_q <= '0;
      dur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      spk_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= StIdle;
        idx_q   <= '0;
        busy_q  <= 1'b0;
        spk_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              if (bus.num_notes == '0) begin
                done_q <= 1'b1;
              end else begin
                last_q  <= last_d;
                idx_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= StLoad;
              end
            end
          end
          StLoad: begin
            half_q  <= rd_half;
            len_q   <= rd_len;
            tone_q  <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            spk_q   <= 1'b0;
            if (rd_len != '0) begin
              state_q <= StPlay;
            end
          end
          StPlay: begin
            // A zero half-period is a rest: tone counter parked, speaker low.
            if (half_q != '0) begin
              if (tone_q == half_m1) begin
                tone_q <= '0;
                spk_q  <= ~spk_q;
              end else begin
                tone_q <= tone_q + HALF_W'(1);
              end
            end
            if (presc_q == PreLast) begin
              presc_q <= '0;
              dur_q   <= dur_nxt;
            end else begin
              presc_q <= presc_q + PRE_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase

        // Shared end-of-entry handling for both completed and skipped notes.
        if (advance) begin
          spk_q <= 1'b0;
          if (is_last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= StLoad;
          end
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
  assign bus.speaker  = spk_q;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Plays a programmable melody on the speaker output. It steps through a small writable note table. Each entry holds a half-period in clocks (0 = rest) and a duration in ticks. The block replaces the fixed free-running divider tap with a sequenced, start/stop-controlled tone source, and sits between board control logic and the speaker pin.

Parameters:
TICK_DIV, 500000, clocks per duration tick (10 ms at 50 MHz); must be >= 2
ADDR_W, 3, note table address width; table depth = 2**ADDR_W
HALF_W, 16, half-period field width
LEN_W, 8, duration field width (ticks)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  write strobe for note table
cfg_addr  in  ADDR_W  table entry to write
cfg_half  in  HALF_W  half-period in clocks; 0 = rest (silence)
cfg_len  in  LEN_W  note duration in ticks; 0 = skip entry
num_notes  in  ADDR_W+1  entries to play (1..2**ADDR_W); sampled on accepted start
start  in  1  level-sampled start request
stop  in  1  abort request
busy  out  1  high while sequence active (LOAD or PLAY)
done  out  1  one-cycle pulse when the last note completes normally
note_idx  out  ADDR_W  index of entry being loaded/played; 0 in IDLE
speaker  out  1  square-wave output

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, note_idx=0, speaker=0. All counters are 0. Table contents are not reset (undefined until written).
- Table: cfg_we writes {cfg_half, cfg_len} at cfg_addr on the clock edge, in any state. The read in LOAD samples the pre-write contents (read-first) when the write targets the same address in the same cycle.
- States: IDLE, LOAD, PLAY.
- IDLE: start=1 and stop=0 is accepted.
  - num_notes latched, idx=0, go to LOAD.
  - If num_notes==0: stay IDLE and pulse done next cycle.
  - num_notes > 2**ADDR_W is clamped to 2**ADDR_W.
- LOAD (1 cycle): fetch table[idx]; load half_r, len_r; clear tone counter and tick prescaler. speaker driven 0.
  - If len==0: the entry is skipped; advance directly (see advance rule), without entering PLAY.
  - Otherwise go to PLAY.
- PLAY:
  - Tone counter increments each clock. When it equals half_r-1, it clears and speaker toggles. First toggle (0->1) occurs on the half_r-th clock after PLAY entry. half_r==0: speaker held 0, tone counter idle.
  - Tick prescaler counts 0..TICK_DIV-1. On wrap, dur counter increments. When dur reaches len_r, the note ends.
  - PLAY dwell = len_r*TICK_DIV clocks exactly.
- Advance rule:
  - If idx == num_notes-1: go IDLE, done=1 for one cycle, speaker=0, note_idx=0.
  - Else: idx+1 and go to LOAD. speaker returns to 0 during LOAD, so each note starts phase-aligned low.
- start while busy: ignored (no restart).
- stop=1 in any state: IDLE next cycle, busy=0, speaker=0, no done pulse. If stop and start are asserted together in IDLE, stop wins.
- busy=1 from the cycle after accepted start until the cycle done pulses (inclusive of final PLAY, exclusive of done cycle).
- done and busy are never high in the same cycle.
- Widths: all counters are unsigned, with no overflow past their compare values. The tone counter is HALF_W bits, the prescaler ceil(log2(TICK_DIV)) bits, and the duration counter LEN_W bits.

Test Plan:
- Reset mid-PLAY (TICK_DIV=4, entry0 half=3 len=5, start, assert rst_n=0 after 7 clocks) -> speaker, busy, note_idx go 0 immediately, without waiting for a clock edge; no done pulse after release.
- Single note: TICK_DIV=4, entry0 half=3 len=2, num_notes=1, start 1 cycle.
  - busy rises next cycle; LOAD 1 cycle, then 8 PLAY cycles.
  - speaker toggles at PLAY cycles 3 and 6.
  - done pulses once; busy falls.
- Three-entry sequence, entry1 rest (half=0, len=1), entry2 len=0 (skip).
  - note_idx goes 0,1,2.
  - speaker stays 0 through entry1.
  - entry2 takes exactly 1 LOAD cycle, then done.
- Stop mid-PLAY of entry1 of 4 -> next cycle IDLE, speaker=0, busy=0, done never pulses. A subsequent start replays from idx 0.
- start held high during PLAY and at the done cycle -> no restart while busy. Restart is accepted on the first IDLE cycle after done; busy rises again. start+stop together in IDLE -> stays idle.
- cfg_we to the active index during PLAY -> the current note is unchanged. The new value is used on the next replay. num_notes=0 -> done pulse, busy never asserted.
